// File: rtl/ram_wseq_pkg.sv
// Shared types and constants for the RAM burst write sequencer.
package ram_wseq_pkg;

  localparam int DW_DEF = 8;
  localparam int AW_DEF = 4;
  localparam int DEPTH  = 2 ** AW_DEF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } wseq_state_t;

endpackage

// File: rtl/ram_addr_ctr.sv
// Loadable wrap-around address counter for RAM port A.
module ram_addr_ctr #(
  parameter int AW = 4
) (
  input  logic          clk0,
  input  logic          rst,
  input  logic          load,
  input  logic          inc,
  input  logic [AW-1:0] load_val,
  output logic [AW-1:0] addr
);

  // Load has priority; increment wraps naturally modulo 2**AW.
  always_ff @(posedge clk0 or negedge rst) begin
    if (!rst) begin
      addr <= '0;
    end else if (load) begin
      addr <= load_val;
    end else if (inc) begin
      addr <= addr + 1'b1;
    end
  end

endmodule

// File: rtl/ram_write_sequencer.sv
// Burst write front-end for port A of the dual-port RAM.
// Optional macro RAM_WSEQ_ERR_EN adds a sticky err output flagging
// out-of-range burst lengths.
//
// state | meaning
// IDLE  | waiting for a burst command, cmd_ready high
// WRITE | accepting bytes, one RAM write per accepted byte
// DONE  | single-cycle completion pulse
module ram_write_sequencer
  import ram_wseq_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF,
  parameter int LW = AW + 1
) (
  input  logic          clk0,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [AW-1:0] cmd_addr,
  input  logic [LW-1:0] cmd_len,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [DW-1:0] s_data,
  output logic [AW-1:0] addr_a,
  output logic [DW-1:0] din_a,
  output logic          we_a,
  output logic          re_a,
  output logic          busy,
  output logic          done,
`ifdef RAM_WSEQ_ERR_EN
  output logic          err,
`endif
  output logic [LW-1:0] wr_count
);

  localparam logic [LW-1:0] DEPTH_LEN = LW'(2 ** AW);

  wseq_state_t   state;
  logic [LW-1:0] remaining;
  logic [LW-1:0] len_sat;
  logic [AW-1:0] cur_addr;
  logic          cmd_acc;
  logic          beat;

  assign cmd_ready = (state == IDLE);
  assign s_ready   = (state == WRITE);
  assign re_a      = 1'b0;
  assign cmd_acc   = cmd_valid & cmd_ready;
  assign beat      = s_valid & s_ready;
  assign len_sat   = (cmd_len > DEPTH_LEN) ? DEPTH_LEN : cmd_len;

  ram_addr_ctr #(.AW(AW)) u_addr_ctr (
    .clk0     (clk0),
    .rst      (rst),
    .load     (cmd_acc),
    .inc      (beat),
    .load_val (cmd_addr),
    .addr     (cur_addr)
  );

  // Burst FSM with registered RAM port and status outputs.
  always_ff @(posedge clk0 or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      remaining <= '0;
      wr_count  <= '0;
      addr_a    <= '0;
      din_a     <= '0;
      we_a      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      we_a <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_acc) begin
            remaining <= len_sat;
            wr_count  <= '0;
            if (len_sat != '0) begin
              state <= WRITE;
              busy  <= 1'b1;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        WRITE: begin
          if (beat) begin
            we_a      <= 1'b1;
            addr_a    <= cur_addr;
            din_a     <= s_data;
            remaining <= remaining - 1'b1;
            wr_count  <= wr_count + 1'b1;
            if (remaining == LW'(1)) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef RAM_WSEQ_ERR_EN
  // Sticky flag: set by an empty or oversized burst, cleared by a legal one.
  always_ff @(posedge clk0 or negedge rst) begin
    if (!rst) begin
      err <= 1'b0;
    end else if (cmd_acc) begin
      err <= (cmd_len == '0) || (cmd_len > DEPTH_LEN);
    end
  end
`endif

endmodule

// File: tb/tb_ram_write_sequencer.sv
// Self-checking bench for ram_write_sequencer with a write scoreboard.
module tb_ram_write_sequencer;

  logic       clk0 = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_addr;
  logic [4:0] cmd_len;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] s_data;
  logic [3:0] addr_a;
  logic [7:0] din_a;
  logic       we_a;
  logic       re_a;
  logic       busy;
  logic       done;
  logic [4:0] wr_count;
`ifdef RAM_WSEQ_ERR_EN
  logic       err;
`endif

  always #5 clk0 = ~clk0;

  ram_write_sequencer dut (
    .clk0      (clk0),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_addr  (cmd_addr),
    .cmd_len   (cmd_len),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .addr_a    (addr_a),
    .din_a     (din_a),
    .we_a      (we_a),
    .re_a      (re_a),
    .busy      (busy),
    .done      (done),
`ifdef RAM_WSEQ_ERR_EN
    .err       (err),
`endif
    .wr_count  (wr_count)
  );

  typedef struct packed {
    logic [3:0] a;
    logic [7:0] d;
  } wr_t;

  wr_t         exp_q[$];
  int          n_chk = 0;
  int          n_fail = 0;
  int          done_cnt = 0;
  logic [7:0]  mem [16];
  logic [15:0] mem_wr = '0;
  logic [3:0]  addr_m = '0;

  // Scoreboard monitor: every RAM write must match the next expected beat.
  always @(negedge clk0) begin
    wr_t w;
    if (we_a === 1'b1) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write addr=%0d data=%h (no write expected)", addr_a, din_a);
      end else begin
        w = exp_q.pop_front();
        if ({addr_a, din_a} !== {w.a, w.d}) begin
          n_fail++;
          $display("FAIL write_order got addr=%0d data=%h, want addr=%0d data=%h",
                   addr_a, din_a, w.a, w.d);
        end
      end
      mem[addr_a] = din_a;
      mem_wr[addr_a] = 1'b1;
    end
    if (done === 1'b1) done_cnt++;
  end

  task automatic send_cmd(input logic [3:0] a, input logic [4:0] l);
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_len   = l;
    addr_m    = a;
    @(posedge clk0); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic stream_beat(input logic [7:0] d);
    s_valid = 1'b1;
    s_data  = d;
    exp_q.push_back({addr_m, d});
    addr_m  = addr_m + 1'b1;
    @(posedge clk0); #1;
    s_valid = 1'b0;
  endtask

  task automatic bubble();
    s_valid = 1'b0;
    @(posedge clk0); #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0;
    s_valid = 1'b0; s_data = '0;
    repeat (3) @(posedge clk0);
    @(negedge clk0);
    n_chk++;
    if ({addr_a, din_a, we_a, re_a, busy, done, wr_count} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs got addr=%0d din=%h we=%b re=%b busy=%b done=%b cnt=%0d, want all 0",
               addr_a, din_a, we_a, re_a, busy, done, wr_count);
    end
    n_chk++;
    if (cmd_ready !== 1'b1 || s_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ready got cmd_ready=%b s_ready=%b, want 1/0", cmd_ready, s_ready);
    end
`ifdef RAM_WSEQ_ERR_EN
    n_chk++;
    if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", err); end
`endif
    @(posedge clk0); #1;
    rst = 1'b1;
    @(posedge clk0); #1;
  endtask

  task automatic test_mid_reset();
    mem_wr = '0;
    send_cmd(4'd2, 5'd8);
    for (int i = 0; i < 3; i++) stream_beat(8'h40 + 8'(i));
    bubble();
    rst = 1'b0;
    #1;
    n_chk++;
    if ({addr_a, din_a, we_a, busy, done, wr_count} !== '0 || cmd_ready !== 1'b1 || s_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_outputs got addr=%0d din=%h we=%b busy=%b done=%b cnt=%0d crdy=%b srdy=%b",
               addr_a, din_a, we_a, busy, done, wr_count, cmd_ready, s_ready);
    end
    s_valid = 1'b1; s_data = 8'hEE;
    repeat (3) @(posedge clk0);
    #1;
    s_valid = 1'b0;
    n_chk++;
    if (mem_wr[4:2] !== 3'b111 || mem_wr[9:5] !== 5'b0) begin
      n_fail++;
      $display("FAIL midreset_mem got written=%b, want [4:2]=111 [9:5]=00000", mem_wr);
    end
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL midreset_queue got %0d pending, want 0", exp_q.size());
    end
    rst = 1'b1;
    @(posedge clk0); #1;
  endtask

  task automatic test_basic();
    logic [7:0] d[4];
    int dc0;
    d[0] = 8'h01; d[1] = 8'h03; d[2] = 8'h07; d[3] = 8'h1A;
    dc0 = done_cnt;
    mem_wr = '0;
    send_cmd(4'd10, 5'd4);
    n_chk++;
    if (busy !== 1'b1 || s_ready !== 1'b1 || cmd_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_write_state got busy=%b srdy=%b crdy=%b, want 1/1/0", busy, s_ready, cmd_ready);
    end
    for (int i = 0; i < 4; i++) stream_beat(d[i]);
    @(negedge clk0);
    n_chk++;
    if (done !== 1'b1 || wr_count !== 5'd4 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_done got done=%b cnt=%0d busy=%b, want 1/4/0", done, wr_count, busy);
    end
    @(posedge clk0); #1;
    n_chk++;
    if (done_cnt - dc0 != 1 || cmd_ready !== 1'b1 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL basic_complete got pulses=%0d crdy=%b pending=%0d, want 1/1/0",
               done_cnt - dc0, cmd_ready, exp_q.size());
    end
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if (mem_wr[10+i] !== 1'b1 || mem[10+i] !== d[i]) begin
        n_fail++;
        $display("FAIL basic_readback addr=%0d got %h, want %h", 10 + i, mem[10+i], d[i]);
      end
    end
  endtask

  task automatic test_wrap_stall();
    bit   pat[6];
    logic [7:0] d[4];
    int   k;
    logic [3:0] ad[4];
    pat = '{1, 0, 1, 1, 0, 1};
    ad[0] = 4'd14; ad[1] = 4'd15; ad[2] = 4'd0; ad[3] = 4'd1;
    k = 0;
    mem_wr = '0;
    send_cmd(4'd14, 5'd4);
    for (int i = 0; i < 6; i++) begin
      if (pat[i]) begin
        d[k] = 8'($urandom_range(0, 255));
        stream_beat(d[k]);
        k++;
      end else begin
        bubble();
      end
    end
    @(negedge clk0);
    n_chk++;
    if (done !== 1'b1 || wr_count !== 5'd4) begin
      n_fail++;
      $display("FAIL wrap_done got done=%b cnt=%0d, want 1/4", done, wr_count);
    end
    @(posedge clk0); #1;
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if (mem_wr[ad[i]] !== 1'b1 || mem[ad[i]] !== d[i]) begin
        n_fail++;
        $display("FAIL wrap_readback addr=%0d got %h, want %h", ad[i], mem[ad[i]], d[i]);
      end
    end
    n_chk++;
    if (mem_wr !== 16'hC003 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL wrap_coverage got written=%h pending=%0d, want c003/0", mem_wr, exp_q.size());
    end
  endtask

  task automatic test_len_edges();
    int dc0;
    mem_wr = '0;
    dc0 = done_cnt;
    send_cmd(4'd7, 5'd0);
    @(negedge clk0);
    n_chk++;
    if (done !== 1'b1 || we_a !== 1'b0 || wr_count !== 5'd0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL len0_done got done=%b we=%b cnt=%0d busy=%b, want 1/0/0/0", done, we_a, wr_count, busy);
    end
`ifdef RAM_WSEQ_ERR_EN
    n_chk++;
    if (err !== 1'b1) begin n_fail++; $display("FAIL len0_err got %b want 1", err); end
`endif
    @(posedge clk0); #1;
    n_chk++;
    if (mem_wr !== 16'h0 || done_cnt - dc0 != 1) begin
      n_fail++;
      $display("FAIL len0_nowrite got written=%h pulses=%0d, want 0/1", mem_wr, done_cnt - dc0);
    end

    send_cmd(4'd3, 5'd20);
    for (int i = 0; i < 16; i++) stream_beat(8'($urandom_range(0, 255)));
    @(negedge clk0);
    n_chk++;
    if (done !== 1'b1 || wr_count !== 5'd16 || s_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL len20_done got done=%b cnt=%0d srdy=%b, want 1/16/0", done, wr_count, s_ready);
    end
`ifdef RAM_WSEQ_ERR_EN
    n_chk++;
    if (err !== 1'b1) begin n_fail++; $display("FAIL len20_err got %b want 1", err); end
`endif
    @(posedge clk0); #1;
    n_chk++;
    if (mem_wr !== 16'hFFFF || exp_q.size() != 0 || cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL len20_coverage got written=%h pending=%0d crdy=%b, want ffff/0/1",
               mem_wr, exp_q.size(), cmd_ready);
    end

    send_cmd(4'd0, 5'd3);
    for (int i = 0; i < 3; i++) stream_beat(8'h90 + 8'(i));
    @(negedge clk0);
    n_chk++;
    if (done !== 1'b1 || wr_count !== 5'd3) begin
      n_fail++;
      $display("FAIL len3_done got done=%b cnt=%0d, want 1/3", done, wr_count);
    end
`ifdef RAM_WSEQ_ERR_EN
    n_chk++;
    if (err !== 1'b0) begin n_fail++; $display("FAIL len3_err_clear got %b want 0", err); end
`endif
    @(posedge clk0); #1;
  endtask

  task automatic test_back_to_back();
    mem_wr = '0;
    send_cmd(4'd5, 5'd3);
    cmd_valid = 1'b1; cmd_addr = 4'd9; cmd_len = 5'd2;
    for (int i = 0; i < 3; i++) begin
      stream_beat(8'hA0 + 8'(i));
      n_chk++;
      if (cmd_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL busy_cmd_ready beat=%0d got %b want 0", i, cmd_ready);
      end
    end
    n_chk++;
    if (done !== 1'b1 || wr_count !== 5'd3) begin
      n_fail++;
      $display("FAIL b2b_first_done got done=%b cnt=%0d, want 1/3", done, wr_count);
    end
    @(posedge clk0); #1;
    n_chk++;
    if (cmd_ready !== 1'b1 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_idle got crdy=%b done=%b, want 1/0", cmd_ready, done);
    end
    addr_m = 4'd9;
    @(posedge clk0); #1;
    cmd_valid = 1'b0;
    stream_beat(8'hB1);
    stream_beat(8'hB2);
    @(negedge clk0);
    n_chk++;
    if (done !== 1'b1 || wr_count !== 5'd2) begin
      n_fail++;
      $display("FAIL b2b_second_done got done=%b cnt=%0d, want 1/2", done, wr_count);
    end
    @(posedge clk0); #1;
    n_chk++;
    if (mem_wr !== 16'h06E0 || mem[9] !== 8'hB1 || mem[10] !== 8'hB2 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL b2b_mem got written=%h m9=%h m10=%h pending=%0d, want 06e0/b1/b2/0",
               mem_wr, mem[9], mem[10], exp_q.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_mid_reset();
    test_basic();
    test_wrap_stall();
    test_len_edges();
    test_back_to_back();
    repeat (2) @(posedge clk0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
